// File: rtl/muldiv_iter.sv
// muldiv_iter: multi-cycle RV32M execution unit.
//   Iterative shift-add multiplier and restoring divider sharing one
//   2*XLEN working register, behind a start/done handshake. Operands are
//   reduced to magnitudes on accept, iterated for XLEN cycles, and the sign
//   is applied in a final FIXUP cycle. Divide-by-zero, signed overflow and
//   unknown op codes complete in the cycle after accept.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request, accepted when idle and kill is low
//   op[4:0]         10000 MUL .. 10111 REMU
//   rdA, rdB        rs1 (dividend / multiplicand), rs2 (divisor / multiplier)
//   tag_in          writeback tag carried with the request
//   kill            flush of the in-flight operation (wins over start)
//   busy            operation in flight
//   done            one-cycle completion pulse
//   result, tag_out registered result and its tag, held until next done
module muldiv_iter #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rdA,
  input  logic [XLEN-1:0] rdB,
  input  logic [TAGW-1:0] tag_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next;     // mul: {hi, multiplier}; div: {rem, quo}
  logic [XLEN-1:0]     opnd_reg, opnd_next;   // multiplicand or divisor magnitude
  logic                is_div_reg, is_div_next;
  logic [1:0]          fn_reg, fn_next;
  logic                neg_reg, neg_next;
  logic [TAGW-1:0]     tag_reg, tag_next;
  logic [XLEN-1:0]     result_reg, result_next;
  logic [TAGW-1:0]     tag_out_reg, tag_out_next;
  logic                done_reg, done_next;

  // Request decode.
  logic            op_valid, in_div, sa_en, sb_en, sign_a, sign_b, in_neg;
  logic            div_zero, div_ovf, early;
  logic [XLEN-1:0] mag_a, mag_b, early_val;

  always_comb begin
    op_valid = (op[4:3] == 2'b10);
    in_div   = op[2];
    // Mul: MULH and MULHSU take rs1 signed, only MULH takes rs2 signed.
    // Div: DIV and REM (op[0] = 0) are the signed forms.
    sa_en    = in_div ? ~op[0] : op[0];
    sb_en    = in_div ? ~op[0] : (op[1:0] == 2'b01);
    sign_a   = sa_en & rdA[XLEN-1];
    sign_b   = sb_en & rdB[XLEN-1];
    mag_a    = sign_a ? -rdA : rdA;
    mag_b    = sign_b ? -rdB : rdB;
    // Remainder takes the dividend's sign; product and quotient take sA^sB.
    in_neg   = (in_div && op[1]) ? sign_a : (sign_a ^ sign_b);

    div_zero = in_div && (rdB == '0);
    div_ovf  = in_div && !op[0] && (rdA == SMIN) && (rdB == '1);
    early    = !op_valid || div_zero || div_ovf;
    if (!op_valid)     early_val = '0;
    else if (div_zero) early_val = op[1] ? rdA : '1;
    else               early_val = op[1] ? '0 : rdA;
  end

  // One iteration of each datapath.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]}
              + ({1'b0, opnd_reg} & {(XLEN+1){acc_reg[0]}});
    mul_step  = {mul_sum, acc_reg[XLEN-1:1]};
    div_shift = acc_reg[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_reg};
    // Borrow out of the trial subtraction means the divisor did not fit.
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};
  end

  // Sign correction and output selection for FIXUP.
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    mul_fix = neg_reg ? -acc_reg : acc_reg;
    quo_fix = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fix = neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    if (is_div_reg)           fix_val = fn_reg[1] ? rem_fix : quo_fix;
    else if (fn_reg == 2'b00) fix_val = mul_fix[XLEN-1:0];
    else                      fix_val = mul_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    acc_next     = acc_reg;
    opnd_next    = opnd_reg;
    is_div_next  = is_div_reg;
    fn_next      = fn_reg;
    neg_next     = neg_reg;
    tag_next     = tag_reg;
    result_next  = result_reg;
    tag_out_next = tag_out_reg;
    done_next    = 1'b0;
    if (kill) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            tag_next    = tag_in;
            is_div_next = in_div;
            fn_next     = op[1:0];
            neg_next    = in_neg;
            count_next  = CW'(XLEN);
            if (in_div) begin
              acc_next  = {{XLEN{1'b0}}, mag_a};
              opnd_next = mag_b;
            end else begin
              acc_next  = {{XLEN{1'b0}}, mag_b};
              opnd_next = mag_a;
            end
            if (early) begin
              result_next  = early_val;
              tag_out_next = tag_in;
              done_next    = 1'b1;
            end else begin
              state_next = CALC;
            end
          end
        end
        CALC: begin
          acc_next   = is_div_reg ? div_step : mul_step;
          count_next = count_reg - CW'(1);
          if (count_reg == CW'(1)) state_next = FIXUP;
        end
        FIXUP: begin
          result_next  = fix_val;
          tag_out_next = tag_reg;
          done_next    = 1'b1;
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
      fn_reg      <= '0;
      neg_reg     <= 1'b0;
      tag_reg     <= '0;
      result_reg  <= '0;
      tag_out_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      acc_reg     <= acc_next;
      opnd_reg    <= opnd_next;
      is_div_reg  <= is_div_next;
      fn_reg      <= fn_next;
      neg_reg     <= neg_next;
      tag_reg     <= tag_next;
      result_reg  <= result_next;
      tag_out_reg <= tag_out_next;
      done_reg    <= done_next;
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign result  = result_reg;
  assign tag_out = tag_out_reg;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed and randomized checks of muldiv_iter (XLEN=32)
// against an arithmetic reference model of the RV32M operations.
module tb_muldiv_iter;
  localparam logic [31:0] SMIN = 32'h8000_0000;
  localparam int NORM_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] rdA = '0;
  logic [31:0] rdB = '0;
  logic [4:0]  tag_in = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_tag = '0;

  muldiv_iter #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rdA(rdA), .rdB(rdB),
    .tag_in(tag_in), .kill(kill), .busy(busy), .done(done),
    .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tg, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic with RISC-V special cases.
  function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      5'b10000: begin p = ua * ub; return p[31:0];  end
      5'b10001: begin p = sa * sb; return p[63:32]; end
      5'b10010: begin p = ua * ub; return p[63:32]; end
      5'b10011: begin p = sa * ub; return p[63:32]; end
      5'b10100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        else if (a == SMIN && b == 32'hFFFF_FFFF) return a;
        else return $signed(a) / $signed(b);
      end
      5'b10101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'b10110: begin
        if (b == 0) return a;
        else if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        else return $signed(a) % $signed(b);
      end
      5'b10111: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic bit ref_early(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[4:3] != 2'b10) return 1'b1;
    if (o[2] && b == 0) return 1'b1;
    if ((o == 5'b10100 || o == 5'b10110) && a == SMIN && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return SMIN;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Present a request for one cycle; returns 1 ns after the accept edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    @(negedge clk);
    start = 1'b1; op = o; rdA = a; rdB = b; tag_in = t;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the current one until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input string tg);
    int lat;
    logic [31:0] exp;
    bit early;
    exp = ref_res(o, a, b);
    early = ref_early(o, a, b);
    issue(o, a, b, t);
    check({tg, "_busy_after_accept"}, busy, early ? 1'b0 : 1'b1);
    wait_done(lat);
    check({tg, "_latency"}, lat, early ? 0 : NORM_LAT);
    check({tg, "_result"}, result, exp);
    check({tg, "_tag"}, tag_out, t);
    check({tg, "_busy_in_done"}, busy, 1'b0);
    last_res = exp;
    last_tag = t;
    $display("%s op=%b a=%h b=%h tag=%0d result=%h exp=%h lat=%0d",
             tg, o, a, b, t, result, exp, lat);
  endtask

  initial begin
    int lat;
    bit seen;

    // Reset state.
    @(posedge clk); #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'h0);
    check("reset_tag", tag_out, 5'h0);
    @(negedge clk); rst = 1'b0;

    // Multiplies.
    do_op(5'b10000, 32'd7, 32'hFFFF_FFFD, 5'd1, "mul_7x-3");
    @(posedge clk); #1;
    check("done_single_pulse", done, 1'b0);
    do_op(5'b10001, SMIN, SMIN, 5'd2, "mulh_min");
    do_op(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhu_ff");
    do_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mulhsu_ff");

    // Divides.
    do_op(5'b10100, 32'hFFFF_FFF9, 32'd2, 5'd5, "div_-7/2");
    do_op(5'b10110, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_-7/2");
    do_op(5'b10101, 32'd100, 32'd7, 5'd7, "divu_100/7");
    do_op(5'b10111, 32'd100, 32'd7, 5'd8, "remu_100/7");

    // Early completions.
    do_op(5'b10101, 32'd5, 32'd0, 5'd9, "divu_by0");
    do_op(5'b10111, 32'd5, 32'd0, 5'd10, "remu_by0");
    do_op(5'b10100, SMIN, 32'hFFFF_FFFF, 5'd11, "div_ovf");
    do_op(5'b10110, SMIN, 32'hFFFF_FFFF, 5'd12, "rem_ovf");
    do_op(5'b00110, 32'd9, 32'd3, 5'd13, "bad_op");

    // kill 10 cycles after accept, with a competing start in the kill cycle.
    do_op(5'b10000, 32'd6, 32'd7, 5'd14, "mul_before_kill");
    issue(5'b10000, 32'd11, 32'd13, 5'd15);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1; start = 1'b1; op = 5'b10101; rdA = 32'd50; rdB = 32'd5; tag_in = 5'd16;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    check("kill_busy", busy, 1'b0);
    check("kill_done", done, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("kill_no_activity", seen, 1'b0);
    check("kill_result_held", result, last_res);
    check("kill_tag_held", tag_out, last_tag);
    $display("kill result=%h tag=%0d", result, tag_out);

    // start together with kill while idle: dropped.
    @(negedge clk);
    kill = 1'b1; start = 1'b1; op = 5'b10000; rdA = 32'd2; rdB = 32'd2; tag_in = 5'd17;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("start_kill_dropped", seen, 1'b0);
    $display("start_with_kill dropped busy=%b done=%b", busy, done);

    // start while busy: ignored, first result intact.
    issue(5'b10001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd18);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 5'b10101; rdA = 32'd100; rdB = 32'd7; tag_in = 5'd19;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("busy_start_latency", lat, NORM_LAT - 6);
    check("busy_start_result", result, ref_res(5'b10001, 32'hDEAD_BEEF, 32'h1234_5678));
    check("busy_start_tag", tag_out, 5'd18);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("busy_start_ignored", seen, 1'b0);
    $display("start_while_busy result=%h tag=%0d", result, tag_out);

    // Back-to-back: second start issued in the done cycle of the first.
    do_op(5'b10100, 32'd1000, 32'hFFFF_FFFD, 5'd20, "b2b_first");
    do_op(5'b10110, 32'd1000, 32'hFFFF_FFFD, 5'd21, "b2b_second");
    do_op(5'b10111, 32'd7, 32'd0, 5'd22, "b2b_early1");
    do_op(5'b10101, 32'd7, 32'd0, 5'd23, "b2b_early2");

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      logic [4:0] o;
      if ($urandom_range(0, 7) == 0) o = 5'($urandom());
      else o = 5'b10000 | 5'($urandom_range(0, 7));
      do_op(o, pick(), pick(), 5'($urandom()), "rand");
    end

    // Asynchronous reset mid-CALC.
    issue(5'b10000, 32'd123, 32'd456, 5'd24);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_result", result, 32'h0);
    check("arst_tag", tag_out, 5'h0);
    $display("async_reset busy=%b done=%b result=%h tag=%0d", busy, done, result, tag_out);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(5'b10000, 32'd3, 32'd5, 5'd25, "mul_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
